store_buffer: RTL and testbench

Write buffer between the MEM stage and the data memory. It accepts full-word stores from the MEM stage into a FIFO and drains one entry per cycle into the data memory whenever the shared memory address port is not needed by a load. Loads are forwarded from the youngest matching buffered store, so the MEM stage never waits for a memory write to complete. It owns the data memory's address, write-data, write-enable and trace-PC inputs, and consumes its read data.

---
 rtl/store_buffer_if.sv | 20 ++
 rtl/store_buffer.sv | 83 ++++++++
 tb/tb_store_buffer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: MEM-stage store/load handshake into the store buffer
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_hit;
  modport master (
    output st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr,
    input  st_ready, ld_data, ld_hit
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr,
    output st_ready, ld_data, ld_hit
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: FIFO of full-word stores draining to data memory, with youngest-match load forwarding
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  store_buffer_if.slave            sb,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wdata,
  output logic                     dm_wren,
  output logic [31:0]              dm_pc4,
  input  logic [31:0]              dm_rd,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [11:0]   addr_q [DEPTH];
  logic [11:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic          push, pop, hit;
  logic [31:0]   fwd;
  logic          unused_st_addr;
  assign unused_st_addr = ^{sb.st_addr[31:14], sb.st_addr[1:0]};
  // Port arbitration (loads win), push/pop and next pointer/entry state
  always_comb begin
    empty       = count_q == '0;
    count       = count_q;
    sb.st_ready = count_q != (AW+1)'(DEPTH);
    push        = sb.st_valid && sb.st_ready;
    dm_wren     = !sb.ld_valid && !empty;
    pop         = dm_wren;
    dm_addr     = sb.ld_valid ? sb.ld_addr : {18'b0, addr_q[head_q], 2'b00};
    dm_wdata    = data_q[head_q];
    dm_pc4      = empty ? '0 : pc_q[head_q] + 32'd4;
    head_d      = head_q + AW'(pop);
    tail_d      = tail_q + AW'(push);
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
    addr_d      = addr_q;
    data_d      = data_q;
    pc_d        = pc_q;
    if (push) begin
      addr_d[tail_q] = sb.st_addr[13:2];
      data_d[tail_q] = sb.st_data;
      pc_d[tail_q]   = sb.st_pc;
    end
  end
  // Forwarding: scan oldest to youngest so the last valid match wins
  always_comb begin
    hit = 1'b0;
    fwd = dm_rd;
    for (int k = 0; k < DEPTH; k++) begin
      if ((AW+1)'(k) < count_q && addr_q[head_q + AW'(k)] == sb.ld_addr[13:2]) begin
        hit = 1'b1;
        fwd = data_q[head_q + AW'(k)];
      end
    end
    sb.ld_hit  = hit && sb.ld_valid;
    sb.ld_data = fwd;
  end
  // Pointers and occupancy; reset discards all pending stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Entry storage needs no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    pc_q   <= pc_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of store buffer draining, forwarding, wrap and reset
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dm_addr, dm_wdata, dm_pc4, dm_rd;
  logic        dm_wren, empty;
  logic [2:0]  count;
  logic [31:0] mem [0:4095];
  logic [31:0] wq [$];
  int          n_chk = 0;
  int          n_pass = 0;
  store_buffer_if sb ();
  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sb(sb),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wren(dm_wren), .dm_pc4(dm_pc4),
    .dm_rd(dm_rd), .empty(empty), .count(count)
  );
  always #5 clk = ~clk;
  assign dm_rd = mem[dm_addr[13:2]];
  always @(posedge clk) begin
    if (dm_wren) begin
      mem[dm_addr[13:2]] <= dm_wdata;
      wq.push_back(dm_wdata);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    sb.st_valid = v;
    sb.st_addr  = a;
    sb.st_data  = d;
    sb.st_pc    = p;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    st(0, 0, 0, 0);
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ready", 32'(sb.st_ready), 1);
    check("rst_wren", 32'(dm_wren), 0);
    check("rst_pc4", dm_pc4, 0);
    check("rst_hit", 32'(sb.ld_hit), 0);
    reset = 1'b1;
    sb.ld_valid = 1'b0;
    cyc();
    st(1, 32'h10, 32'hDEADBEEF, 32'h3000);
    cyc();
    st(0, 0, 0, 0);
    #1;
    check("s1_wren", 32'(dm_wren), 1);
    check("s1_addr", dm_addr, 32'h10);
    check("s1_wdata", dm_wdata, 32'hDEADBEEF);
    check("s1_pc4", dm_pc4, 32'h3004);
    cyc();
    check("s1_empty", 32'(empty), 1);
    check("s1_mem", mem[4], 32'hDEADBEEF);
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h100;
    for (int i = 0; i < 4; i++) begin
      st(1, 32'h200 + 32'(4*i), 32'hA0 + 32'(i), 32'h4000 + 32'(4*i));
      cyc();
    end
    st(1, 32'h210, 32'hBAD, 32'h4010);
    #1;
    check("fill_count", 32'(count), 4);
    check("fill_ready", 32'(sb.st_ready), 0);
    check("fill_nowr", 32'(dm_wren), 0);
    cyc();
    check("fill_refused", 32'(count), 4);
    st(0, 0, 0, 0);
    sb.ld_valid = 1'b0;
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_wren", 32'(dm_wren), 1);
      check("drain_data", dm_wdata, 32'hA0 + 32'(i));
      check("drain_pc4", dm_pc4, 32'h4004 + 32'(4*i));
      cyc();
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_n", 32'(wq.size()), 4);
    mem[9] = 32'h5555;
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h100;
    st(1, 32'h20, 32'h1111, 32'h5000);
    cyc();
    st(1, 32'h20, 32'h2222, 32'h5004);
    cyc();
    st(0, 0, 0, 0);
    sb.ld_addr = 32'h20;
    #1;
    check("fwd_hit", 32'(sb.ld_hit), 1);
    check("fwd_data", sb.ld_data, 32'h2222);
    check("fwd_nowr", 32'(dm_wren), 0);
    sb.ld_addr = 32'h24;
    #1;
    check("miss_hit", 32'(sb.ld_hit), 0);
    check("miss_data", sb.ld_data, 32'h5555);
    cyc();
    sb.ld_valid = 1'b0;
    cyc();
    cyc();
    check("fwd_mem", mem[8], 32'h2222);
    check("fwd_empty", 32'(empty), 1);
    wq.delete();
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h100;
    for (int i = 0; i < 2; i++) begin
      st(1, 32'h300 + 32'(4*i), 32'hC0 + 32'(i), 32'h6000);
      cyc();
    end
    sb.ld_valid = 1'b0;
    for (int i = 2; i < 14; i++) begin
      st(1, 32'h300 + 32'(4*i), 32'hC0 + 32'(i), 32'h6000);
      cyc();
      check("pp_count", 32'(count), 2);
    end
    st(0, 0, 0, 0);
    cyc();
    cyc();
    check("pp_n", 32'(wq.size()), 14);
    for (int i = 0; i < 14 && i < wq.size(); i++) check("pp_order", wq[i], 32'hC0 + 32'(i));
    sb.ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st(1, 32'h500 + 32'(4*i), 32'hE0 + 32'(i), 32'h7000);
      cyc();
    end
    st(0, 0, 0, 0);
    #1;
    check("mr_count3", 32'(count), 3);
    wq.delete();
    sb.ld_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mr_wren", 32'(dm_wren), 0);
    check("mr_count", 32'(count), 0);
    cyc();
    #3;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("mr_nowrite", 32'(wq.size()), 0);
    check("mr_mem", mem[12'h140], 0);
    check("mr_empty", 32'(empty), 1);
    mem[16] = 32'h1234;
    st(1, 32'h40, 32'h7777, 32'h8000);
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h40;
    #1;
    check("same_hit", 32'(sb.ld_hit), 0);
    check("same_data", sb.ld_data, 32'h1234);
    cyc();
    st(0, 0, 0, 0);
    #1;
    check("next_hit", 32'(sb.ld_hit), 1);
    check("next_data", sb.ld_data, 32'h7777);
    sb.ld_valid = 1'b0;
    cyc();
    check("same_mem", mem[16], 32'h7777);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
